// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction-fetch front end.
// Issues PC_STEP-spaced requests to an in-order, variable-latency instruction memory,
// buffers {pc, instr} pairs in a DEPTH-entry FIFO for decode, and flushes on redirect.
// Responses to requests issued before a redirect are counted in drop_cnt and discarded.
// Optional build macro FETCH_QUEUE_PERF_EN adds perf_stall_cnt, perf_flush_cnt and
// perf_drop_cnt saturating counters.
module fetch_queue #(
   parameter int                ADDR_W   = 64,
   parameter int                INSTR_W  = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               out_ready
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt,
   output logic [31:0]        perf_drop_cnt
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int SUM_W = CNT_W + 2;
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
   localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   inflight_q, inflight_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [INSTR_W-1:0] instr_d [DEPTH];
   logic [ADDR_W-1:0]  pc_q [DEPTH];
   logic [ADDR_W-1:0]  pc_d [DEPTH];
   logic [DEPTH-1:0]   entry_we;

   logic               credit_ok;
   logic               req_fire;
   logic               rsp_push;
   logic               rsp_drop;
   logic               pop;
   logic               wr_en;
   logic [SUM_W-1:0]   occupancy;
   logic [CNT_W:0]     drop_sum;

   // Every buffered, in-flight or to-be-dropped fetch holds one FIFO slot, so a push
   // can never meet a full FIFO.
   assign occupancy = SUM_W'(count_q) + SUM_W'(inflight_q) + SUM_W'(drop_cnt_q);
   assign credit_ok = occupancy < SUM_W'(DEPTH);

   assign imem_req_valid = !rst && !redirect_valid && credit_ok;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
   assign rsp_push       = imem_rsp_valid && (drop_cnt_q == '0);
   assign out_valid      = !rst && (count_q != '0);
   assign pop            = out_valid && out_ready;
   assign wr_en          = rsp_push && !redirect_valid;
   assign out_instr      = instr_q[rd_ptr_q];
   assign out_pc         = pc_q[rd_ptr_q];

   // Per-entry write selection and next value for the FIFO storage.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_we[gi] = wr_en && (wr_ptr_q == PTR_W'(gi));
      assign instr_d[gi]  = entry_we[gi] ? imem_rsp_data : instr_q[gi];
      assign pc_d[gi]     = entry_we[gi] ? rsp_pc_q : pc_q[gi];
   end

   // Next-state for PCs, FIFO bookkeeping and fetch accounting; redirect overrides all.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      drop_cnt_d = drop_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      drop_sum   = (CNT_W + 1)'(drop_cnt_q) + (CNT_W + 1)'(inflight_q);

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         inflight_d = '0;
         // A response landing this cycle retires one outstanding fetch, stale or not.
         if (imem_rsp_valid && (drop_sum != '0)) begin
            drop_sum = drop_sum - (CNT_W + 1)'(1);
         end
         drop_cnt_d = drop_sum[CNT_W-1:0];
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + STEP;
         end
         if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_ONE;
         end
         if (rsp_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            rsp_pc_d = rsp_pc_q + STEP;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({req_fire, rsp_push})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
         endcase
         case ({rsp_push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         drop_cnt_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // FIFO storage; cleared on reset so the head is never X.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end else begin
            instr_q[i] <= instr_d[i];
            pc_q[i]    <= pc_d[i];
         end
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;
   logic [31:0] perf_drop_q, perf_drop_d;

   // Saturating event counters: decode starved, redirects, discarded responses.
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      perf_drop_d  = perf_drop_q;
      if (out_ready && !out_valid && (perf_stall_q != '1)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (redirect_valid && (perf_flush_q != '1)) begin
         perf_flush_d = perf_flush_q + 32'd1;
      end
      if (imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0)) && (perf_drop_q != '1)) begin
         perf_drop_d = perf_drop_q + 32'd1;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
         perf_drop_q  <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
         perf_drop_q  <= perf_drop_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
   assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end; the next-generation replacement for the fixed PC register, +4 adder and branch mux path.
- Issues sequential fetch requests to an instruction memory with variable latency, using a valid/ready request channel and an in-order response channel.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- On a redirect (taken branch or unconditional branch), flushes buffered and in-flight fetches and restarts at the target.

Parameters:
- ADDR_W, 64, width of PC and memory address.
- INSTR_W, 32, instruction width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 0, fetch address after reset.
- PC_STEP, 4, increment between sequential fetches.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  ADDR_W  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  ADDR_W  fetch address.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  response valid; responses arrive in order, latency at least 1 cycle.
- imem_rsp_data  in  INSTR_W  fetched instruction.
- out_valid  out  1  instruction available to decode.
- out_instr  out  INSTR_W  instruction at FIFO head.
- out_pc  out  ADDR_W  PC of the head instruction.
- out_ready  in  1  decode consumes the head.

Behaviour:
- State: fetch_pc, rsp_pc, FIFO (count, rd_ptr, wr_ptr), inflight, drop_cnt. All counters are sized for 0..DEPTH.
- Reset (rst high at a clock edge): fetch_pc = RESET_PC, rsp_pc = RESET_PC, count/inflight/drop_cnt/pointers = 0.
  - out_valid = 0 and imem_req_valid = 0 while rst is high.
  - First request (addr RESET_PC) is asserted in the cycle after rst deasserts.
- Credit: imem_req_valid = !rst && !redirect_valid && (count + inflight + drop_cnt < DEPTH). imem_req_addr = fetch_pc.
- Request accept (valid && ready): fetch_pc += PC_STEP (modulo 2^ADDR_W); inflight += 1.
- Response with drop_cnt > 0: discarded; drop_cnt -= 1.
- Response with drop_cnt == 0: {rsp_pc, data} written at wr_ptr; rsp_pc += PC_STEP; inflight -= 1; count += 1.
- Output: out_valid = (count != 0); out_instr and out_pc come from rd_ptr.
  - No bypass: a response at edge t is visible on out_* in cycle t+1.
  - Pop when out_valid && out_ready; count -= 1.
- Simultaneous push and pop: both happen; count is unchanged. Credit guarantees a push never meets a full FIFO.
- Pointers wrap modulo DEPTH.
- Redirect (redirect_valid at an edge) has priority over all other updates:
  - FIFO cleared (count and pointers = 0).
  - fetch_pc = rsp_pc = redirect_pc.
  - drop_cnt = drop_cnt + inflight, minus 1 if a response arrives in the same cycle.
  - inflight = 0.
  - A pop in the redirect cycle completes from decode's view; the FIFO is still cleared.
  - Back-to-back redirects accumulate drop_cnt correctly.
- Reset mid-operation: immediate return to the reset state. The memory must not return responses to requests issued before reset.
- out_* values when out_valid = 0 are don't-care, but must not be X after reset.

Optional Feature:
- Macro FETCH_QUEUE_PERF_EN.
- When defined, adds outputs perf_stall_cnt [31:0], perf_flush_cnt [31:0] and perf_drop_cnt [31:0]:
  - perf_stall_cnt increments each cycle with out_ready && !out_valid.
  - perf_flush_cnt increments per redirect.
  - perf_drop_cnt increments per discarded response.
  - All three are cleared by rst and saturate at 0xFFFFFFFF.
- When undefined, these ports and all associated logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then memory with 1-cycle latency and out_ready = 1 → out_pc sequence 0x0, 0x4, 0x8, ... with one instruction per cycle in steady state; first out_valid in the third cycle after reset release.
- Hold out_ready = 0 with DEPTH = 4 → exactly 4 requests issued, then imem_req_valid = 0; count = 4; out_pc = 0x0 held until out_ready rises.
- Memory with 3-cycle latency and 2 requests in flight; redirect to 0x100 → both stale responses dropped; next out_pc = 0x100 with the instruction from address 0x100.
- Redirect in the same cycle as a response arrival and a pop → no stale instruction appears; fetch restarts at the target; drop_cnt ends at 0.
- imem_req_ready toggling randomly with fetch_pc near 2^64-8 → PCs wrap to 0x0 with no skipped or duplicated addresses.
- With FETCH_QUEUE_PERF_EN: 5 cycles of out_ready with an empty FIFO plus 2 redirects → perf_stall_cnt = 5, perf_flush_cnt = 2.
